alarm_timer: RTL and testbench
==============================

ALARM_TIMER -- requirements
Module: alarm_timer

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, clock cycles per second; even, >= 4.
REQ-002 SHALL have port clock  in  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-004 SHALL have port start_timer  in  1  level from the anti-theft FSM; only its rising edge acts.
REQ-005 SHALL have port value  in  4  countdown length in seconds, 0..15, from the time-parameter block.
REQ-006 SHALL have port expired  out  1  countdown reached zero; held until next start edge or reset.
REQ-007 SHALL have port busy  out  1  countdown in progress.
REQ-008 SHALL have port remaining  out  4  seconds left.
REQ-009 SHALL have port one_hz_enable  out  1  one-cycle pulse per second.
REQ-010 SHALL have port two_hz_enable  out  1  one-cycle pulse per half second, feeds the siren generator.

Function
REQ-011 SHALL run a prescaler counting 0..CLK_FREQ/2-1; two_hz_enable pulses for the one cycle after it wraps.
REQ-012 SHALL pulse one_hz_enable on every second two_hz_enable pulse, coincident with it.
REQ-013 SHALL detect a start edge as start_timer=1 in the current cycle with start_timer=0 in the previous registered sample.
REQ-014 SHALL, on a start edge, clear the prescaler and half-second phase, so the first one_hz_enable occurs exactly CLK_FREQ cycles later.
REQ-015 SHALL implement states IDLE, COUNT, DONE.
REQ-016 SHALL, on a start edge in any state, load remaining=value, clear expired, and enter COUNT, or DONE if value=0.
REQ-017 SHALL, in COUNT, decrement remaining by 1 on each one_hz_enable; at 1->0, enter DONE.
REQ-018 SHALL assert expired registered, the cycle after DONE is entered, and hold it while in DONE.
REQ-019 SHALL keep busy=1 exactly while in COUNT.
REQ-020 SHALL give a start edge in COUNT (restart) priority over a coincident decrement; the new value loads and the prescaler restarts.
REQ-021 SHALL produce only one load when start_timer is held high; a new load requires start_timer to fall and rise again.
REQ-022 SHALL keep remaining as unsigned 4-bit, never wrap below 0, and sample value only on the start edge.
REQ-023 SHALL keep the prescaler free-running in IDLE and DONE, so two_hz_enable stays periodic.

Reset
REQ-024 SHALL, while reset=0 at a clock edge, force state=IDLE, remaining=0, expired=0, busy=0, one_hz_enable=0, two_hz_enable=0, prescaler=0, and edge-detect history=1.
REQ-025 SHALL, with history=1 at reset, require start_timer held high through reset to fall first before a load occurs.
REQ-026 SHALL, on reset mid-count, abandon the count with no expired pulse.

Configuration
REQ-027 SHALL, with macro ALARM_TIMER_PAUSE_EN defined, add input hold (1 bit); while hold=1, prescaler, half-second phase, and remaining freeze and no enable pulses are issued, while start edges still load.
REQ-028 SHALL, without ALARM_TIMER_PAUSE_EN, have no hold port and never freeze.

Structure
REQ-029 SHALL place the state enum (IDLE/COUNT/DONE) and constant VALUE_W=4 in shared package alarm_pkg, also used by the anti-theft FSM and time-parameter block.
REQ-030 SHALL implement the prescaler as sub-module tick_prescaler, with inputs clear and hold and outputs half_tick and full_tick.

Verification (CLK_FREQ=8)
REQ-031 SHALL check: reset=0 for 3 cycles -> all outputs 0; after release, two_hz_enable every 4 cycles and one_hz_enable every 8 cycles.
REQ-032 SHALL check: value=3, start edge at cycle T -> remaining 3,2,1,0 at T+9, T+17, T+25; busy falls and expired rises at T+26 and stays high.
REQ-033 SHALL check: value=0, start edge at T -> busy never 1; expired=1 from T+2.
REQ-034 SHALL check: value=5 counting, start edge with value=2 at 10 cycles in -> remaining=2, expired 17 cycles after restart edge.
REQ-035 SHALL check: start_timer held high 60 cycles with value=2 -> single load; expired stays high after expiry.
REQ-036 SHALL check: reset=0 mid-count -> outputs 0 next cycle; with ALARM_TIMER_PAUSE_EN, hold=1 for 10 cycles delays expired by exactly 10 cycles.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared alarm-system definitions: countdown state encoding and value width.
// Also consumed by the anti-theft FSM and the time-parameter block.
package alarm_pkg;

  localparam int VALUE_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } alarm_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Half-second prescaler: counts 0..CLK_FREQ/2-1 and strobes half_tick/full_tick
// combinationally in the wrap cycle; clear restarts the phase, hold freezes it.
module tick_prescaler #(
  parameter int CLK_FREQ = 50000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic hold,
  output logic half_tick,
  output logic full_tick
);

  localparam int HALF  = CLK_FREQ / 2;
  localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             wrap;

  assign wrap = (cnt_q == CNT_W'(HALF - 1));

  // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    half_tick = 1'b0;
    full_tick = 1'b0;
    if (clear) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (!hold) begin
      if (wrap) begin
        cnt_d     = '0;
        phase_d   = ~phase_q;
        half_tick = 1'b1;
        full_tick = phase_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/alarm_timer.sv
// Alarm countdown timer with 1 Hz / 2 Hz enables; reloads on each start_timer rising edge.
// Optional macro ALARM_TIMER_PAUSE_EN adds a hold input that freezes the countdown.
module alarm_timer
  import alarm_pkg::*;
#(
  parameter int CLK_FREQ = 50000000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start_timer,
  input  logic [VALUE_W-1:0] value,
`ifdef ALARM_TIMER_PAUSE_EN
  input  logic               hold,
`endif
  output logic               expired,
  output logic               busy,
  output logic [VALUE_W-1:0] remaining,
  output logic               one_hz_enable,
  output logic               two_hz_enable
);

  alarm_state_e       state_q, state_d;
  logic [VALUE_W-1:0] remaining_q, remaining_d;
  logic               expired_q, busy_q, one_hz_q, two_hz_q;
  logic               start_hist_q;
  logic               start_edge, hold_w;
  logic               half_tick, full_tick;

`ifdef ALARM_TIMER_PAUSE_EN
  assign hold_w = hold;
`else
  assign hold_w = 1'b0;
`endif

  // History resets high so a start_timer held through reset must fall before it can load.
  assign start_edge = start_timer & ~start_hist_q;

  tick_prescaler #(
    .CLK_FREQ (CLK_FREQ)
  ) u_prescaler (
    .clock     (clock),
    .reset     (reset),
    .clear     (start_edge),
    .hold      (hold_w),
    .half_tick (half_tick),
    .full_tick (full_tick)
  );

  // A start edge outranks a coincident decrement; the prescaler clear suppresses that tick anyway.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    if (start_edge) begin
      remaining_d = value;
      state_d     = (value == '0) ? DONE : COUNT;
    end else if (state_q == COUNT && full_tick && remaining_q != '0) begin
      remaining_d = remaining_q - VALUE_W'(1);
      if (remaining_q == VALUE_W'(1)) state_d = DONE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      expired_q    <= 1'b0;
      busy_q       <= 1'b0;
      one_hz_q     <= 1'b0;
      two_hz_q     <= 1'b0;
      start_hist_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      expired_q    <= ~start_edge & (state_q == DONE);
      busy_q       <= (state_q == COUNT);
      one_hz_q     <= full_tick;
      two_hz_q     <= half_tick;
      start_hist_q <= start_timer;
    end
  end

  assign expired       = expired_q;
  assign busy          = busy_q;
  assign remaining     = remaining_q;
  assign one_hz_enable = one_hz_q;
  assign two_hz_enable = two_hz_q;

endmodule

// File: tb/tb_alarm_timer.sv
// Self-checking bench for alarm_timer at CLK_FREQ=8: directed scenarios plus a randomized
// run against an elapsed-time reference model. Exercises hold when ALARM_TIMER_PAUSE_EN is set.
module tb_alarm_timer;

  localparam int CLK_FREQ = 8;
  localparam int HALF     = CLK_FREQ / 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start_timer = 1'b0;
  logic [3:0] value = 4'd0;
  logic       hold = 1'b0;
  logic       expired, busy, one_hz_enable, two_hz_enable;
  logic [3:0] remaining;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: elapsed un-held cycles since the last start edge or reset.
  bit         m_prev = 1'b1, m_loaded = 1'b0, m_counting = 1'b0, m_finished = 1'b0;
  int         m_k = 0, m_v = 0;
  logic [3:0] e_rem = 4'd0;
  logic       e_busy = 1'b0, e_exp = 1'b0, e_one = 1'b0, e_two = 1'b0;

  always #5 clock = ~clock;

  alarm_timer #(
    .CLK_FREQ (CLK_FREQ)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start_timer   (start_timer),
    .value         (value),
`ifdef ALARM_TIMER_PAUSE_EN
    .hold          (hold),
`endif
    .expired       (expired),
    .busy          (busy),
    .remaining     (remaining),
    .one_hz_enable (one_hz_enable),
    .two_hz_enable (two_hz_enable)
  );

  // One clock edge: advance the reference model with the sampled inputs, then settle.
  task automatic step();
    bit se, pc, pf;
    int secs;
    @(posedge clock);
    if (!reset) begin
      m_prev = 1'b1; m_loaded = 1'b0; m_k = 0; m_v = 0;
      m_counting = 1'b0; m_finished = 1'b0;
      e_rem = 4'd0; e_busy = 1'b0; e_exp = 1'b0; e_one = 1'b0; e_two = 1'b0;
    end else begin
      se     = start_timer && !m_prev;
      m_prev = start_timer;
      pc     = m_counting;
      pf     = m_finished;
      if (se) begin
        m_loaded = 1'b1; m_v = int'(value); m_k = 0;
        e_one = 1'b0; e_two = 1'b0;
      end else if (hold) begin
        e_one = 1'b0; e_two = 1'b0;
      end else begin
        m_k++;
        e_two = (m_k % HALF) == 0;
        e_one = (m_k % CLK_FREQ) == 0;
      end
      secs       = (m_k / CLK_FREQ < m_v) ? m_k / CLK_FREQ : m_v;
      e_rem      = m_loaded ? 4'(m_v - secs) : 4'd0;
      m_counting = m_loaded && (m_k < CLK_FREQ * m_v);
      m_finished = m_loaded && (m_k >= CLK_FREQ * m_v);
      e_busy     = pc;
      e_exp      = pf && !se;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start_timer = 1'b0;
    repeat (3) begin
      step();
      n_checks++;
      if ({expired, busy, remaining, one_hz_enable, two_hz_enable} !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_outputs: got %b required 00000000",
                 {expired, busy, remaining, one_hz_enable, two_hz_enable});
      end
    end
    reset = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      step();
      n_checks++;
      if (two_hz_enable !== ((i % 4) == 0)) begin
        n_fail++;
        $display("FAIL two_hz_period cyc %0d: got %b required %b", i, two_hz_enable, (i % 4) == 0);
      end
      n_checks++;
      if (one_hz_enable !== ((i % 8) == 0)) begin
        n_fail++;
        $display("FAIL one_hz_period cyc %0d: got %b required %b", i, one_hz_enable, (i % 8) == 0);
      end
    end
  endtask

  task automatic test_countdown();
    start_timer = 1'b0; step();
    value = 4'd3; start_timer = 1'b1; step();
    start_timer = 1'b0;
    for (int j = 1; j <= 32; j++) begin
      step();
      if (j == 7 || j == 8 || j == 16 || j == 24) begin
        n_checks++;
        if (remaining !== 4'(3 - j / 8)) begin
          n_fail++;
          $display("FAIL countdown_remaining j=%0d: got %0d required %0d", j, remaining, 3 - j / 8);
        end
      end
      n_checks++;
      if (busy !== (j <= 24)) begin
        n_fail++;
        $display("FAIL countdown_busy j=%0d: got %b required %b", j, busy, j <= 24);
      end
      n_checks++;
      if (expired !== (j >= 25)) begin
        n_fail++;
        $display("FAIL countdown_expired j=%0d: got %b required %b", j, expired, j >= 25);
      end
    end
  endtask

  task automatic test_zero_value();
    start_timer = 1'b0; step();
    value = 4'd0; start_timer = 1'b1; step();
    start_timer = 1'b0;
    n_checks++;
    if (expired !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_load: got expired=%b busy=%b required 0 0", expired, busy);
    end
    for (int j = 1; j <= 12; j++) begin
      step();
      n_checks++;
      if (expired !== 1'b1 || busy !== 1'b0 || remaining !== 4'd0) begin
        n_fail++;
        $display("FAIL zero_done j=%0d: got expired=%b busy=%b rem=%0d required 1 0 0",
                 j, expired, busy, remaining);
      end
    end
  endtask

  task automatic test_restart();
    start_timer = 1'b0; step();
    value = 4'd5; start_timer = 1'b1; step();
    start_timer = 1'b0;
    repeat (9) step();
    value = 4'd2; start_timer = 1'b1; step();
    start_timer = 1'b0;
    n_checks++;
    if (remaining !== 4'd2) begin
      n_fail++;
      $display("FAIL restart_load: got %0d required 2", remaining);
    end
    for (int j = 1; j <= 22; j++) begin
      step();
      if (j == 8) begin
        n_checks++;
        if (remaining !== 4'd1) begin
          n_fail++;
          $display("FAIL restart_remaining: got %0d required 1", remaining);
        end
      end
      n_checks++;
      if (expired !== (j >= 17)) begin
        n_fail++;
        $display("FAIL restart_expired j=%0d: got %b required %b", j, expired, j >= 17);
      end
    end
  endtask

  task automatic test_held_start();
    start_timer = 1'b0; step();
    value = 4'd2; start_timer = 1'b1; step();
    for (int j = 1; j <= 59; j++) begin
      value = 4'($urandom_range(1, 15));
      step();
      if (j == 8 || j >= 16) begin
        n_checks++;
        if (remaining !== ((j >= 16) ? 4'd0 : 4'd1)) begin
          n_fail++;
          $display("FAIL held_remaining j=%0d: got %0d required %0d", j, remaining, (j >= 16) ? 0 : 1);
        end
      end
      n_checks++;
      if (expired !== (j >= 17)) begin
        n_fail++;
        $display("FAIL held_expired j=%0d: got %b required %b", j, expired, j >= 17);
      end
    end
    start_timer = 1'b0; step();
    n_checks++;
    if (expired !== 1'b1) begin
      n_fail++;
      $display("FAIL held_release: got expired=%b required 1", expired);
    end
  endtask

  task automatic test_reset_midcount();
    start_timer = 1'b0; step();
    value = 4'd7; start_timer = 1'b1; step();
    start_timer = 1'b0;
    repeat (12) step();
    reset = 1'b0; step();
    n_checks++;
    if ({expired, busy, remaining, one_hz_enable, two_hz_enable} !== 8'h00) begin
      n_fail++;
      $display("FAIL midcount_reset: got %b required 00000000",
               {expired, busy, remaining, one_hz_enable, two_hz_enable});
    end
    reset = 1'b1;
    for (int j = 1; j <= 70; j++) begin
      step();
      n_checks++;
      if (expired !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL abandoned_count j=%0d: got expired=%b busy=%b required 0 0", j, expired, busy);
      end
    end
    // start_timer held high through reset must not load on release
    reset = 1'b0; start_timer = 1'b1; value = 4'd5;
    repeat (2) step();
    reset = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      step();
      n_checks++;
      if (busy !== 1'b0 || remaining !== 4'd0) begin
        n_fail++;
        $display("FAIL held_through_reset j=%0d: got busy=%b rem=%0d required 0 0", j, busy, remaining);
      end
    end
    start_timer = 1'b0; step();
    value = 4'd1; start_timer = 1'b1; step();
    start_timer = 1'b0;
    n_checks++;
    if (remaining !== 4'd1) begin
      n_fail++;
      $display("FAIL load_after_fall: got %0d required 1", remaining);
    end
  endtask

`ifdef ALARM_TIMER_PAUSE_EN
  task automatic test_hold();
    start_timer = 1'b0; hold = 1'b0; step();
    value = 4'd2; start_timer = 1'b1; step();
    start_timer = 1'b0;
    repeat (4) step();
    hold = 1'b1;
    for (int j = 5; j <= 14; j++) begin
      step();
      n_checks++;
      if (one_hz_enable !== 1'b0 || two_hz_enable !== 1'b0 || remaining !== 4'd2) begin
        n_fail++;
        $display("FAIL hold_freeze j=%0d: got one=%b two=%b rem=%0d required 0 0 2",
                 j, one_hz_enable, two_hz_enable, remaining);
      end
    end
    hold = 1'b0;
    for (int j = 15; j <= 34; j++) begin
      step();
      n_checks++;
      if (expired !== (j >= 27)) begin
        n_fail++;
        $display("FAIL hold_delay j=%0d: got %b required %b", j, expired, j >= 27);
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 699) != 0);
      if ($urandom_range(0, 49) == 0) start_timer = ~start_timer;
      value = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
`ifdef ALARM_TIMER_PAUSE_EN
      if ($urandom_range(0, 24) == 0) hold = ~hold;
`endif
      step();
      n_checks++;
      if (remaining !== e_rem) begin
        n_fail++;
        $display("FAIL rand_remaining cyc %0d: got %0d required %0d", c, remaining, e_rem);
      end
      n_checks++;
      if (busy !== e_busy) begin
        n_fail++;
        $display("FAIL rand_busy cyc %0d: got %b required %b", c, busy, e_busy);
      end
      n_checks++;
      if (expired !== e_exp) begin
        n_fail++;
        $display("FAIL rand_expired cyc %0d: got %b required %b", c, expired, e_exp);
      end
      n_checks++;
      if (one_hz_enable !== e_one || two_hz_enable !== e_two) begin
        n_fail++;
        $display("FAIL rand_enables cyc %0d: got one=%b two=%b required %b %b",
                 c, one_hz_enable, two_hz_enable, e_one, e_two);
      end
    end
    reset = 1'b1;
    hold  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_zero_value();
    test_restart();
    test_held_start();
    test_reset_midcount();
`ifdef ALARM_TIMER_PAUSE_EN
    test_hold();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
